// File: rtl/pipelined_shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
package shifter_pkg;

  localparam int DEFAULT_WIDTH  = 24;
  localparam int DEFAULT_AMT_W  = 8;
  localparam int DEFAULT_STAGES = 2;

  // Operation select, encoded exactly as carried on in_mode.
  typedef enum logic [1:0] {
    SHR_LOG = 2'b00,
    SHL_LOG = 2'b01,
    SHR_ARI = 2'b10,
    ROR     = 2'b11
  } shift_mode_t;

  // Lowest shift-amount bit handled by stage k. Stage k covers
  // [slice_lo(k), slice_lo(k+1)-1], so slices are contiguous, LSB first,
  // and together cover every amount bit exactly once.
  function automatic int slice_lo(input int k, input int stages, input int amt_w);
    return (k * amt_w) / stages;
  endfunction

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// One pipeline stage: shifts by its own slice of the amount bits, folds the
// bits it discards into the running sticky flag, and registers the result
// together with a valid flag.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = DEFAULT_AMT_W,
  parameter int LO    = 0,
  parameter int HI    = DEFAULT_AMT_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [AMT_W-1:0] up_amt,
  input  logic [1:0]       up_mode,
  input  logic             up_sticky,
  input  logic             dn_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  output logic [AMT_W-1:0] dn_amt,
  output logic [1:0]       dn_mode,
  output logic             dn_sticky
);

  localparam logic [AMT_W-1:0] ONES    = '1;
  localparam logic [AMT_W-1:0] MASK    = (ONES << LO) & ~(ONES << (HI + 1));
  localparam logic [31:0]      WIDTH_U = 32'(WIDTH);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] amt_q;
  logic [1:0]       mode_q;
  logic             sticky_q;

  logic [WIDTH-1:0] data_d;
  logic             sticky_d;
  logic [AMT_W-1:0] shamt;
  logic [AMT_W-1:0] rot_amt;
  logic [WIDTH-1:0] lost_mask;
  logic             load;

  // The stage may take a new beat when it is empty or its beat leaves now.
  assign load = !valid_q || dn_ready;

  // Shift by this stage's slice; shift counts >= WIDTH flush naturally.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    data_d    = up_data;
    sticky_d  = up_sticky;
    shamt     = up_amt & MASK;
    rot_amt   = AMT_W'(32'(shamt) % WIDTH_U);
    lost_mask = ~({WIDTH{1'b1}} << shamt);
    case (shift_mode_t'(up_mode))
      SHR_LOG: begin
        data_d   = up_data >> shamt;
        sticky_d = up_sticky | (|(up_data & lost_mask));
      end
      SHL_LOG: data_d = up_data << shamt;
      SHR_ARI: begin
        // Sign-fill bits discarded later are copies of the sign bit, which
        // has already been discarded by then, so the OR stays exact.
        data_d   = $unsigned($signed(up_data) >>> shamt);
        sticky_d = up_sticky | (|(up_data & lost_mask));
      end
      ROR: data_d = (up_data >> rot_amt) | (up_data << (WIDTH_U - 32'(rot_amt)));
      default: data_d = up_data;
    endcase
  end

  // Stage register: holds while stalled, loads a beat or a bubble otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the payload registers are reset along with the valid flag so the
    // outputs read zero during reset, not leftover data.
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amt_q    <= '0;
      mode_q   <= '0;
      sticky_q <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values regardless of block evaluation order.
      valid_q <= up_valid;
      if (up_valid) begin
        data_q   <= data_d;
        amt_q    <= up_amt;
        mode_q   <= up_mode;
        sticky_q <= sticky_d;
      end
    end
  end

  assign dn_valid  = valid_q;
  assign dn_data   = data_q;
  assign dn_amt    = amt_q;
  assign dn_mode   = mode_q;
  assign dn_sticky = sticky_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready on both sides. STAGES copies of
// shift_stage each consume one slice of the amount; latency is STAGES.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int AMT_W  = DEFAULT_AMT_W,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  // Index k is the input of stage k; index STAGES is the pipeline output.
  logic [STAGES:0]            vld_w;
  logic [STAGES:0]            rdy_w;
  logic [STAGES:0]            stk_w;
  logic [STAGES:0][WIDTH-1:0] dat_w;
  logic [STAGES:0][AMT_W-1:0] amt_w;
  logic [STAGES:0][1:0]       mode_w;
  logic                       accept_en_q;
  logic                       unused_tail;

  // Input side stays closed during reset and opens on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) accept_en_q <= 1'b0;
    else     accept_en_q <= 1'b1;
  end

  assign vld_w[0]  = in_valid & accept_en_q;
  assign dat_w[0]  = in_data;
  assign amt_w[0]  = in_amt;
  assign mode_w[0] = in_mode;
  assign stk_w[0]  = 1'b0;

  // Ready into stage k, written in closed form (some stage from k onward is
  // empty, or the output is taken) so it depends only on registered valids
  // and out_ready, never on in_valid.
  assign rdy_w[STAGES] = out_ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_ready
    assign rdy_w[k] = out_ready | ~(&vld_w[STAGES:k+1]);
  end

  assign in_ready = accept_en_q & rdy_w[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W),
      .LO    (slice_lo(k, STAGES, AMT_W)),
      .HI    (slice_lo(k + 1, STAGES, AMT_W) - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (vld_w[k]),
      .up_data   (dat_w[k]),
      .up_amt    (amt_w[k]),
      .up_mode   (mode_w[k]),
      .up_sticky (stk_w[k]),
      .dn_ready  (rdy_w[k+1]),
      .dn_valid  (vld_w[k+1]),
      .dn_data   (dat_w[k+1]),
      .dn_amt    (amt_w[k+1]),
      .dn_mode   (mode_w[k+1]),
      .dn_sticky (stk_w[k+1])
    );
  end

  // The amount and mode are fully consumed by the last stage.
  assign unused_tail = ^{amt_w[STAGES], mode_w[STAGES]};

  assign out_valid  = vld_w[STAGES];
  assign out_data   = dat_w[STAGES];
  assign out_sticky = stk_w[STAGES];

endmodule
